// File: rtl/bottle_pkg.sv
// rtl/bottle_pkg.sv - shared types and constants for the bottle-filling datapath
package bottle_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT      = 4'd9;
  localparam int   DEB_CYCLES_DEFAULT = 4;

  // A target of 00 or any non-BCD digit cannot be filled meaningfully.
  function automatic logic cfg_bad(input bcd_t h, input bcd_t l);
    return (h > BCD_MAX_DIGIT) || (l > BCD_MAX_DIGIT) || ((h == 4'd0) && (l == 4'd0));
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - 2-flop synchronizer, stable-count debouncer, rising-edge pulse
import bottle_pkg::*;

module sensor_debounce #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int DEB_W      = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic pulse,
  output logic level
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q + 1'b1 == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/pill_sensor_ctrl.sv
// rtl/pill_sensor_ctrl.sv - debounced pill counter with BCD target compare and bottle handshake
import bottle_pkg::*;

module pill_sensor_ctrl #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int DEB_W      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_work,
  input  logic       sensor_in,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  input  logic       bot_ack,
  output logic [3:0] nowL,
  output logic [3:0] nowH,
  output logic       bot_done,
  output logic       busy,
  output logic       spill_err,
  output logic       cfg_err
);

  logic deb_pulse, deb_level;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W     (DEB_W)
  ) u_deb (
    .CLK  (CLK),
    .RST  (RST),
    .din  (sensor_in),
    .pulse(deb_pulse),
    .level(deb_level)
  );

  state_t state_q, state_d;
  bcd_t   now_l_q, now_l_d, now_h_q, now_h_d;
  logic   evt_q, evt_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;
  logic   spill_q, spill_d;
  logic   cfg_err_q, cfg_err_d;

  bcd_t   inc_l, inc_h, cur_l, cur_h;
  logic   reached;

  always_comb begin
    cfg_err_d = cfg_bad(maxH, maxL);
    evt_d     = deb_pulse & deb_level;
    state_d   = state_q;
    now_l_d   = now_l_q;
    now_h_d   = now_h_q;
    spill_d   = spill_q;

    // BCD +1 with saturation at 99
    inc_l = now_l_q;
    inc_h = now_h_q;
    if (now_l_q != BCD_MAX_DIGIT) begin
      inc_l = now_l_q + 4'd1;
    end else if (now_h_q != BCD_MAX_DIGIT) begin
      inc_l = 4'd0;
      inc_h = now_h_q + 4'd1;
    end

    cur_l   = evt_q ? inc_l : now_l_q;
    cur_h   = evt_q ? inc_h : now_h_q;
    reached = (cur_h > maxH) || ((cur_h == maxH) && (cur_l >= maxL));

    if (cfg_err_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (EN_work) state_d = COUNT;
        end
        COUNT: begin
          if (!EN_work) begin
            state_d = IDLE;
          end else begin
            now_l_d = cur_l;
            now_h_d = cur_h;
            if (reached) state_d = DONE;
          end
        end
        DONE: begin
          if (bot_ack) begin
            // A pill landing with the swap belongs to the fresh bottle.
            now_h_d = 4'd0;
            now_l_d = (EN_work && evt_q) ? 4'd1 : 4'd0;
            state_d = EN_work ? COUNT : IDLE;
          end else if (evt_q) begin
            spill_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    done_d = (state_d == DONE);
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      now_l_q   <= 4'd0;
      now_h_q   <= 4'd0;
      evt_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      spill_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      now_l_q   <= now_l_d;
      now_h_q   <= now_h_d;
      evt_q     <= evt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      spill_q   <= spill_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign nowL      = now_l_q;
  assign nowH      = now_h_q;
  assign bot_done  = done_q;
  assign busy      = busy_q;
  assign spill_err = spill_q;
  assign cfg_err   = cfg_err_q;

endmodule
